core_memory_arbiter: RTL and testbench

Two-port arbiter that shares the core's single memory bus between the instruction-fetch port and the load/store data port, ahead of the address-decoding memory controller (local memory / Wishbone split). It serialises requests with a registered round-robin grant and holds the grant for one complete transaction. A per-transaction watchdog converts a hung downstream access into a faulted completion.

---
 rtl/core_memory_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_core_memory_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_memory_arbiter.sv
// core_memory_arbiter
// Shares the core's single memory bus between the instruction-fetch port and
// the load/store data port. A registered round-robin grant is held for one
// complete transaction, and a per-transaction watchdog turns a hung
// downstream access into a faulted completion.
module core_memory_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TIMEOUT_WIDTH  = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instrAddress,
    input  logic        instrReadEnable,
    output logic [31:0] instrDataRead,
    output logic        instrBusy,
    output logic        instrFault,
    input  logic [31:0] dataAddress,
    input  logic [3:0]  dataByteSelect,
    input  logic        dataWriteEnable,
    input  logic        dataReadEnable,
    input  logic [31:0] dataDataWrite,
    output logic [31:0] dataDataRead,
    output logic        dataBusy,
    output logic        dataFault,
    output logic [31:0] memAddress,
    output logic [3:0]  memByteSelect,
    output logic        memWriteEnable,
    output logic        memReadEnable,
    output logic [31:0] memDataWrite,
    input  logic [31:0] memDataRead,
    input  logic        memBusy
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] GRANT_INSTR = 2'd1;
    localparam logic [1:0] GRANT_DATA  = 2'd2;

    localparam logic LAST_INSTR = 1'b0;
    localparam logic LAST_DATA  = 1'b1;

    localparam logic                     TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] COUNT_ZERO   = {TIMEOUT_WIDTH{1'b0}};
    localparam logic [TIMEOUT_WIDTH-1:0] COUNT_ONE    = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_WIDTH-1:0] COUNT_MAX    = {TIMEOUT_WIDTH{1'b1}};

    logic [1:0]               state_r;
    logic [1:0]               state_next_s;
    logic                     last_grant_r;
    logic [TIMEOUT_WIDTH-1:0] count_r;

    logic instr_req_s;
    logic data_req_s;
    logic grant_req_s;
    logic timeout_s;
    logic complete_s;

    assign instr_req_s = instrReadEnable;
    assign data_req_s  = dataReadEnable | dataWriteEnable;

    // Request level of whichever port currently owns the bus.
    always_comb begin
        grant_req_s = 1'b0;
        case (state_r)
            GRANT_INSTR: grant_req_s = instr_req_s;
            GRANT_DATA:  grant_req_s = data_req_s;
            default:     grant_req_s = 1'b0;
        endcase
    end

    // Watchdog fires in the last allowed cycle only while memory still stalls.
    assign timeout_s  = TIMEOUT_EN & memBusy & (count_r == TIMEOUT_LAST);
    assign complete_s = grant_req_s & (~memBusy | timeout_s);

    // Round-robin arbitration in IDLE; a grant ends on completion or abort.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (instr_req_s && data_req_s) begin
                    if (last_grant_r == LAST_INSTR) begin
                        state_next_s = GRANT_DATA;
                    end else begin
                        state_next_s = GRANT_INSTR;
                    end
                end else if (instr_req_s) begin
                    state_next_s = GRANT_INSTR;
                end else if (data_req_s) begin
                    state_next_s = GRANT_DATA;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GRANT_INSTR, GRANT_DATA: begin
                if (!grant_req_s || complete_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, last-granted port and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= LAST_INSTR;
            count_r      <= COUNT_ZERO;
        end else begin
            state_r <= state_next_s;
            if ((state_r == IDLE) && (state_next_s != IDLE)) begin
                count_r      <= COUNT_ZERO;
                last_grant_r <= (state_next_s == GRANT_DATA) ? LAST_DATA : LAST_INSTR;
            end else if ((state_r != IDLE) && memBusy && (count_r != COUNT_MAX)) begin
                count_r      <= count_r + COUNT_ONE;
                last_grant_r <= last_grant_r;
            end else begin
                count_r      <= count_r;
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Bus forwarding and port responses; the idle port only reflects its request.
    always_comb begin
        memAddress     = 32'h0;
        memByteSelect  = 4'h0;
        memWriteEnable = 1'b0;
        memReadEnable  = 1'b0;
        memDataWrite   = 32'h0;
        instrDataRead  = 32'h0;
        instrFault     = 1'b0;
        instrBusy      = instr_req_s;
        dataDataRead   = 32'h0;
        dataFault      = 1'b0;
        dataBusy       = data_req_s;
        case (state_r)
            GRANT_INSTR: begin
                memAddress    = instrAddress;
                memByteSelect = 4'b1111;
                memReadEnable = instrReadEnable;
                if (complete_s) begin
                    instrBusy = 1'b0;
                    if (timeout_s) begin
                        instrFault    = 1'b1;
                        instrDataRead = 32'h0;
                    end else begin
                        instrFault    = 1'b0;
                        instrDataRead = memDataRead;
                    end
                end else begin
                    instrBusy = instr_req_s;
                end
            end
            GRANT_DATA: begin
                memAddress     = dataAddress;
                memByteSelect  = dataByteSelect;
                memWriteEnable = dataWriteEnable;
                memReadEnable  = dataReadEnable;
                memDataWrite   = dataDataWrite;
                if (complete_s) begin
                    dataBusy = 1'b0;
                    if (timeout_s) begin
                        dataFault    = 1'b1;
                        dataDataRead = 32'h0;
                    end else begin
                        dataFault    = 1'b0;
                        dataDataRead = memDataRead;
                    end
                end else begin
                    dataBusy = data_req_s;
                end
            end
            default: begin
                memAddress = 32'h0;
            end
        endcase
    end

endmodule

// File: tb/tb_core_memory_arbiter.sv
// Testbench for core_memory_arbiter: directed scenarios followed by a
// randomized phase checked by a transaction scoreboard and bus monitor.
module tb_core_memory_arbiter;

    localparam int T = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [31:0] instrAddress = 32'h0;
    logic        instrReadEnable = 1'b0;
    logic [31:0] instrDataRead;
    logic        instrBusy, instrFault;
    logic [31:0] dataAddress = 32'h0;
    logic [3:0]  dataByteSelect = 4'h0;
    logic        dataWriteEnable = 1'b0;
    logic        dataReadEnable = 1'b0;
    logic [31:0] dataDataWrite = 32'h0;
    logic [31:0] dataDataRead;
    logic        dataBusy, dataFault;
    logic [31:0] memAddress;
    logic [3:0]  memByteSelect;
    logic        memWriteEnable, memReadEnable;
    logic [31:0] memDataWrite;
    logic [31:0] memDataRead = 32'h0;
    logic        memBusy = 1'b0;

    core_memory_arbiter #(.TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .instrAddress(instrAddress), .instrReadEnable(instrReadEnable),
        .instrDataRead(instrDataRead), .instrBusy(instrBusy), .instrFault(instrFault),
        .dataAddress(dataAddress), .dataByteSelect(dataByteSelect),
        .dataWriteEnable(dataWriteEnable), .dataReadEnable(dataReadEnable),
        .dataDataWrite(dataDataWrite), .dataDataRead(dataDataRead),
        .dataBusy(dataBusy), .dataFault(dataFault),
        .memAddress(memAddress), .memByteSelect(memByteSelect),
        .memWriteEnable(memWriteEnable), .memReadEnable(memReadEnable),
        .memDataWrite(memDataWrite), .memDataRead(memDataRead), .memBusy(memBusy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic        re;
        logic [31:0] wdata;
    } txn_t;

    txn_t q_i[$];
    txn_t q_d[$];

    int n_checks = 0;
    int n_fail   = 0;

    bit          mon_en   = 1'b0;
    bit          ovr_en   = 1'b1;
    bit          ovr_busy = 1'b0;
    logic [31:0] ovr_data = 32'h0;

    int done_i = 0, done_d = 0;
    int k = 0;
    int wins_i = 0, wins_d = 0;

    int r_cnt = 0;
    int r_wait = 0;

    // Memory controller model: directed override or random wait states and data.
    always @(posedge clk) begin
        #2;
        if (ovr_en) begin
            memBusy     = ovr_busy;
            memDataRead = ovr_data;
            r_cnt       = 0;
        end else if (memReadEnable || memWriteEnable) begin
            if (r_cnt == 0) r_wait = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
            memBusy     = (r_cnt < r_wait);
            memDataRead = $urandom();
            r_cnt++;
        end else begin
            r_cnt       = 0;
            memBusy     = ($urandom_range(0, 1) == 1);
            memDataRead = $urandom();
        end
    end

    // Hard stop if the run ever stalls.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic mem_any();
        return memReadEnable | memWriteEnable | (|memAddress) | (|memByteSelect) | (|memDataWrite);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #3;
    endtask

    // Scoreboard monitor: compares the bus and the owning port against the queued request.
    task automatic monitor_cycle();
        logic i_req, d_req, en, comp, tmo;
        txn_t t;
        i_req = instrReadEnable;
        d_req = dataReadEnable | dataWriteEnable;
        en    = memReadEnable | memWriteEnable;
        if (!en) begin
            k = 0;
            chkb("idle_mem_zero", mem_any(), 1'b0);
            chkb("idle_instr_busy", instrBusy, i_req);
            chkb("idle_data_busy", dataBusy, d_req);
            chkb("idle_faults", instrFault | dataFault, 1'b0);
            chk("idle_instr_rdata", instrDataRead, 32'h0);
            chk("idle_data_rdata", dataDataRead, 32'h0);
        end else begin
            k++;
            tmo  = memBusy && (k == T);
            comp = !memBusy || tmo;
            if (memAddress[31]) begin
                if (q_d.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL data_grant_unrequested: got grant at %h, expected no grant", memAddress);
                end else begin
                    t = q_d[0];
                    chk("d_addr", memAddress, t.addr);
                    chk("d_be", {28'h0, memByteSelect}, {28'h0, t.be});
                    chkb("d_we", memWriteEnable, t.we);
                    chkb("d_re", memReadEnable, t.re);
                    chk("d_wdata", memDataWrite, t.wdata);
                    chkb("d_busy", dataBusy, !comp);
                    chkb("d_fault", dataFault, tmo);
                    chk("d_rdata", dataDataRead, (comp && !tmo) ? memDataRead : 32'h0);
                    chkb("i_busy_while_d", instrBusy, i_req);
                    chkb("i_fault_while_d", instrFault, 1'b0);
                    chk("i_rdata_while_d", instrDataRead, 32'h0);
                    if (comp) begin
                        void'(q_d.pop_front());
                        done_d++;
                        chkb("d_fairness", wins_d <= 1, 1'b1);
                        wins_d = 0;
                        if (i_req) wins_i++;
                    end
                end
            end else begin
                if (q_i.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL instr_grant_unrequested: got grant at %h, expected no grant", memAddress);
                end else begin
                    t = q_i[0];
                    chk("i_addr", memAddress, t.addr);
                    chk("i_be", {28'h0, memByteSelect}, 32'hF);
                    chkb("i_we", memWriteEnable, 1'b0);
                    chkb("i_re", memReadEnable, 1'b1);
                    chk("i_wdata", memDataWrite, 32'h0);
                    chkb("i_busy", instrBusy, !comp);
                    chkb("i_fault", instrFault, tmo);
                    chk("i_rdata", instrDataRead, (comp && !tmo) ? memDataRead : 32'h0);
                    chkb("d_busy_while_i", dataBusy, d_req);
                    chkb("d_fault_while_i", dataFault, 1'b0);
                    chk("d_rdata_while_i", dataDataRead, 32'h0);
                    if (comp) begin
                        void'(q_i.pop_front());
                        done_i++;
                        chkb("i_fairness", wins_i <= 1, 1'b1);
                        wins_i = 0;
                        if (d_req) wins_d++;
                    end
                end
            end
        end
    endtask

    // Stimulus, directed checks and the randomized scoreboard run.
    initial begin
        txn_t t;
        int seen_i, seen_d;
        bit i_act, d_act;
        int op;
        seen_i = 0; seen_d = 0; i_act = 1'b0; d_act = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (mon_en) monitor_cycle();
                else k = 0;
            end
        join_none

        // Reset, then a single zero-wait fetch.
        ovr_data = 32'h1234_5678;
        cyc();
        cyc();
        smp();
        chkb("rst_mem_zero", mem_any(), 1'b0);
        chkb("rst_busy", instrBusy | dataBusy, 1'b0);
        chkb("rst_fault", instrFault | dataFault, 1'b0);
        chk("rst_rdata", instrDataRead | dataDataRead, 32'h0);
        cyc();
        rst_n = 1'b1; instrAddress = 32'h0000_0100; instrReadEnable = 1'b1;
        smp();
        chkb("fetch_wait_busy", instrBusy, 1'b1);
        chkb("fetch_wait_no_mem", memReadEnable, 1'b0);
        cyc();
        smp();
        chkb("fetch_re", memReadEnable, 1'b1);
        chk("fetch_be", {28'h0, memByteSelect}, 32'hF);
        chk("fetch_addr", memAddress, 32'h0000_0100);
        chkb("fetch_busy", instrBusy, 1'b0);
        chk("fetch_rdata", instrDataRead, 32'h1234_5678);
        chkb("fetch_fault", instrFault, 1'b0);
        cyc();
        instrReadEnable = 1'b0;
        smp();
        chkb("fetch_idle", mem_any(), 1'b0);

        // Contention with zero-wait memory: D, I, D, I.
        cyc();
        instrAddress = 32'h0000_0020; instrReadEnable = 1'b1;
        dataAddress = 32'h8000_0010; dataReadEnable = 1'b1; dataByteSelect = 4'hF;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            smp();
            if ((c % 2) == 1) begin
                if ((((c - 1) / 2) % 2) == 0) begin
                    chk("rr_addr_d", memAddress, 32'h8000_0010);
                    chkb("rr_loser_i_busy", instrBusy, 1'b1);
                    chkb("rr_winner_d_done", dataBusy, 1'b0);
                end else begin
                    chk("rr_addr_i", memAddress, 32'h0000_0020);
                    chkb("rr_loser_d_busy", dataBusy, 1'b1);
                    chkb("rr_winner_i_done", instrBusy, 1'b0);
                end
            end else begin
                chkb("rr_gap_idle", memReadEnable, 1'b0);
                chkb("rr_gap_busy", instrBusy & dataBusy, 1'b1);
            end
        end
        cyc();
        instrReadEnable = 1'b0;
        smp();
        chkb("rr_tail_d_busy", dataBusy, 1'b1);
        cyc();
        smp();
        chk("rr_tail_d_addr", memAddress, 32'h8000_0010);
        chkb("rr_tail_d_done", dataBusy, 1'b0);

        // Store with three wait states.
        cyc();
        dataReadEnable = 1'b0; dataWriteEnable = 1'b1; dataAddress = 32'h1000_0040;
        dataByteSelect = 4'b0011; dataDataWrite = 32'hAABB_CCDD; ovr_busy = 1'b1;
        for (int g = 1; g <= 4; g++) begin
            cyc();
            ovr_busy = (g < 4);
            smp();
            chkb("ws_we", memWriteEnable, 1'b1);
            chk("ws_addr", memAddress, 32'h1000_0040);
            chk("ws_be", {28'h0, memByteSelect}, 32'h3);
            chk("ws_wdata", memDataWrite, 32'hAABB_CCDD);
            chkb("ws_busy", dataBusy, g < 4);
            chkb("ws_fault", dataFault, 1'b0);
        end
        cyc();
        dataWriteEnable = 1'b0; ovr_busy = 1'b1;
        smp();
        chkb("ws_idle", mem_any(), 1'b0);

        // Fetch with memBusy stuck high while a load waits.
        cyc();
        instrAddress = 32'h0000_0200; instrReadEnable = 1'b1;
        dataAddress = 32'h9000_0000; dataReadEnable = 1'b1; dataByteSelect = 4'hF;
        for (int g = 1; g <= 8; g++) begin
            cyc();
            smp();
            chk("to_addr", memAddress, 32'h0000_0200);
            chkb("to_busy", instrBusy, g < 8);
            chkb("to_fault", instrFault, g == 8);
            chk("to_rdata", instrDataRead, 32'h0);
            chkb("to_data_waits", dataBusy, 1'b1);
        end
        cyc();
        instrReadEnable = 1'b0;
        smp();
        chkb("to_idle", mem_any(), 1'b0);
        chkb("to_idle_d_busy", dataBusy, 1'b1);
        cyc();
        ovr_busy = 1'b0;
        smp();
        chk("to_next_addr", memAddress, 32'h9000_0000);
        chkb("to_next_done", dataBusy, 1'b0);
        chk("to_next_rdata", dataDataRead, 32'h1234_5678);

        // Abort: granted load drops its enable while memory stalls.
        cyc();
        dataAddress = 32'h8000_0080; ovr_busy = 1'b1;
        smp();
        chkb("ab_idle_req", dataBusy, 1'b1);
        cyc();
        smp();
        chkb("ab_granted", memReadEnable, 1'b1);
        chk("ab_addr", memAddress, 32'h8000_0080);
        cyc();
        dataReadEnable = 1'b0;
        smp();
        chkb("ab_mem_off", memReadEnable | memWriteEnable, 1'b0);
        chkb("ab_fault", dataFault, 1'b0);
        chkb("ab_busy", dataBusy, 1'b0);
        cyc();
        instrAddress = 32'h0000_0300; instrReadEnable = 1'b1; ovr_busy = 1'b0;
        smp();
        chkb("ab_then_idle", mem_any(), 1'b0);
        chkb("ab_then_i_busy", instrBusy, 1'b1);
        cyc();
        smp();
        chk("ab_regrant", memAddress, 32'h0000_0300);
        chkb("ab_regrant_done", instrBusy, 1'b0);
        cyc();
        instrReadEnable = 1'b0;

        // Reset during a data grant: bus drops, tie afterwards goes to data.
        cyc();
        dataAddress = 32'h8000_00C0; dataReadEnable = 1'b1; ovr_busy = 1'b1;
        cyc();
        smp();
        chk("rm_granted", memAddress, 32'h8000_00C0);
        cyc();
        rst_n = 1'b0;
        smp();
        chkb("rm_still_granted", memReadEnable, 1'b1);
        cyc();
        rst_n = 1'b1; instrAddress = 32'h0000_0400; instrReadEnable = 1'b1;
        smp();
        chkb("rm_mem_zero", mem_any(), 1'b0);
        chkb("rm_d_busy", dataBusy, 1'b1);
        chkb("rm_i_busy", instrBusy, 1'b1);
        cyc();
        ovr_busy = 1'b0;
        smp();
        chk("rm_tie_data", memAddress, 32'h8000_00C0);
        chkb("rm_tie_data_done", dataBusy, 1'b0);
        cyc();
        dataReadEnable = 1'b0;
        cyc();
        smp();
        chk("rm_instr_after", memAddress, 32'h0000_0400);
        chkb("rm_instr_done", instrBusy, 1'b0);
        cyc();
        instrReadEnable = 1'b0;
        cyc();

        // Randomized traffic through the scoreboard.
        ovr_en = 1'b0;
        mon_en = 1'b1;
        for (int c = 0; c < 3300; c++) begin
            cyc();
            if (i_act && (done_i != seen_i)) begin
                seen_i = done_i; i_act = 1'b0; instrReadEnable = 1'b0;
            end
            if (d_act && (done_d != seen_d)) begin
                seen_d = done_d; d_act = 1'b0; dataReadEnable = 1'b0; dataWriteEnable = 1'b0;
            end
            if (!i_act) instrAddress = $urandom();
            if (!d_act) dataAddress = $urandom();
            if (c < 3000 && !i_act && ($urandom_range(0, 2) == 0)) begin
                t.addr = $urandom() & 32'h7FFF_FFFC; t.be = 4'hF; t.we = 1'b0; t.re = 1'b1; t.wdata = 32'h0;
                q_i.push_back(t);
                instrAddress = t.addr; instrReadEnable = 1'b1; i_act = 1'b1;
            end
            if (c < 3000 && !d_act && ($urandom_range(0, 2) == 0)) begin
                op = int'($urandom_range(0, 2));
                t.addr = $urandom() | 32'h8000_0000;
                t.be = 4'($urandom());
                t.we = (op != 0);
                t.re = (op != 1);
                t.wdata = $urandom();
                q_d.push_back(t);
                dataAddress = t.addr; dataByteSelect = t.be; dataWriteEnable = t.we;
                dataReadEnable = t.re; dataDataWrite = t.wdata; d_act = 1'b1;
            end
        end
        chkb("drain_complete", i_act | d_act, 1'b0);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
